// File: rtl/ifetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/grant/response bus, decoder
// valid/ready handshake and the redirect input, with master (fetch) and slave views.
interface ifetch_unit_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output instr_valid_o,
        output instr_o,
        output pc_o,
        input  instr_ready_i
    );

    modport slave (
        output redirect_i,
        output redirect_pc_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  instr_valid_o,
        input  instr_o,
        input  pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, {pc,instr} FIFO, redirect flush.
// Define IFETCH_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module ifetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk_i,
    input logic           rst_ni,
    ifetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_FLUSH
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] discard_cnt_q, discard_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic        fifo_empty;
    logic        credit_ok;
    logic        req;
    logic        gnt_fire;
    logic        rsp_valid;
    logic        rsp_keep;
    logic        bypass_fire;
    logic        instr_valid;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc_aligned;

    assign fifo_empty          = (fifo_cnt_q == '0);
    assign credit_ok           = (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
    assign req                 = (state_q == ST_FETCH) && !bus.redirect_i && credit_ok;
    assign gnt_fire            = req && bus.imem_gnt_i;
    assign redirect_pc_aligned = bus.redirect_pc_i & ~32'h0000_0003;

    // A response with nothing outstanding can only be a leftover from before a reset.
    assign rsp_valid = bus.imem_rvalid_i && (state_q != ST_RESET) && (out_cnt_q != '0);
    assign rsp_keep  = rsp_valid && (discard_cnt_q == '0) && !bus.redirect_i;

`ifdef IFETCH_BYPASS_EN
    assign bypass_fire = rsp_keep && fifo_empty;
`else
    assign bypass_fire = 1'b0;
`endif

    assign instr_valid = (!fifo_empty || bypass_fire) && !bus.redirect_i;
    assign pop         = !fifo_empty && instr_valid && bus.instr_ready_i;
    // A bypassed word only needs a FIFO slot when the decoder stalls it.
    assign push        = rsp_keep && !(bypass_fire && bus.instr_ready_i);

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = bypass_fire ? bus.imem_rdata_i : mem_instr_q[rd_ptr_q];
    assign bus.pc_o          = bypass_fire ? rsp_pc_q : mem_pc_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        out_cnt_d     = out_cnt_q + CW'(gnt_fire) - CW'(rsp_valid);
        discard_cnt_d = discard_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_valid && (discard_cnt_q != '0)) begin
            discard_cnt_d = discard_cnt_q - CW'(1);
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_FLUSH: state_d = (discard_cnt_d == '0) ? ST_FETCH : ST_FLUSH;
            default:  state_d = ST_RESET;
        endcase

        // Redirect overrides everything: every request still in flight becomes stale.
        if (bus.redirect_i) begin
            fetch_pc_d    = redirect_pc_aligned;
            rsp_pc_d      = redirect_pc_aligned;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fifo_cnt_d    = '0;
            out_cnt_d     = out_cnt_q - CW'(rsp_valid);
            discard_cnt_d = out_cnt_d;
            state_d       = (discard_cnt_d != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RESET;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Entries are cleared on reset so instr_o/pc_o read as zero until the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
            mem_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: memory model, redirects, async reset.
module tb_ifetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    ifetch_unit_if bus ();

    ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_next_pc;
    logic [31:0] mem_addr_q [$];
    int          mem_due_q  [$];

    int gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
    int lat_min = 1, lat_max = 1;
    logic        force_redirect = 1'b0;
    logic [31:0] force_target   = '0;
    int grants = 0, accepts = 0;
    int release_cyc = 0, first_gnt_cyc = -1, first_valid_cyc = -1;
    logic        chk_first_addr = 1'b0;
    logic [31:0] first_addr     = '0;
    logic        chk_req_next   = 1'b0;
    logic [31:0] req_next_addr  = '0;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic cycle();
        logic        redir;
        logic [31:0] tgt;
        int          due;
        @(negedge clk);
        cyc++;
        redir = force_redirect || (redir_pct > 0 && int'($urandom_range(99)) < redir_pct);
        tgt   = force_redirect ? force_target : $urandom;
        force_redirect = 1'b0;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.imem_gnt_i    = int'($urandom_range(99)) < gnt_pct;
        bus.instr_ready_i = int'($urandom_range(99)) < rdy_pct;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
        #1;
        if (chk_req_next && !redir) begin
            check("req_after_idle_redirect", 32'(bus.imem_req_o), 32'd1);
            check("addr_after_idle_redirect", bus.imem_addr_o, req_next_addr);
        end
        chk_req_next = 1'b0;
        if (bus.instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.imem_req_o && bus.imem_gnt_i) begin
            grants++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            if (chk_first_addr) begin
                check("first_addr", bus.imem_addr_o, first_addr);
                chk_first_addr = 1'b0;
            end
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (mem_due_q.size() > 0 && due <= mem_due_q[$]) due = mem_due_q[$] + 1;
            mem_addr_q.push_back(bus.imem_addr_o);
            mem_due_q.push_back(due);
            exp_q.push_back(exp_next_pc);
            exp_next_pc = exp_next_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            exp_next_pc    = tgt & ~32'h3;
            chk_first_addr = 1'b1;
            first_addr     = tgt & ~32'h3;
            chk_req_next   = (mem_due_q.size() == 0);
            req_next_addr  = tgt & ~32'h3;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input bit async_mid);
        if (async_mid) begin
            @(negedge clk);
            #2 rst_ni = 1'b0;
            #1;
            check("rst_req", 32'(bus.imem_req_o), 32'd0);
            check("rst_addr", bus.imem_addr_o, RESET_PC);
            check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
            check("rst_instr", bus.instr_o, 32'd0);
            check("rst_pc", bus.pc_o, 32'd0);
        end else begin
            rst_ni = 1'b0;
        end
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_next_pc     = RESET_PC;
        chk_first_addr  = 1'b1;
        first_addr      = RESET_PC;
        chk_req_next    = 1'b0;
        grants          = 0;
        first_gnt_cyc   = -1;
        first_valid_cyc = -1;
        release_cyc     = cyc;
        rst_ni          = 1'b1;
    endtask

    // Monitor: compares every accepted instruction against the expected queue.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0, prev_instr = '0;
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (!rst_ni) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.redirect_i) begin
                check("valid_in_redirect", 32'(bus.instr_valid_o), 32'd0);
                check("req_in_redirect", 32'(bus.imem_req_o), 32'd0);
            end else if (prev_hold) begin
                check("hold_valid", 32'(bus.instr_valid_o), 32'd1);
                check("hold_pc", bus.pc_o, prev_pc);
                check("hold_instr", bus.instr_o, prev_instr);
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h, want no instruction (cycle %0d)", bus.pc_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pc", bus.pc_o, e);
                    check("instr", bus.instr_o, mem_word(e));
                end
            end
            prev_hold  = bus.instr_valid_o && !bus.instr_ready_i && !bus.redirect_i;
            prev_pc    = bus.pc_o;
            prev_instr = bus.instr_o;
        end
    end

    initial begin
        int n;
        // Back-pressure from reset: credits cap the grants, output holds pc 0.
        do_reset(1'b0);
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        run(10);
        check("credit_grants", 32'(grants), 32'(DEPTH));
        check("credit_req_low", 32'(bus.imem_req_o), 32'd0);
        check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
        check("stall_pc", bus.pc_o, 32'h0);
        rdy_pct = 100;
        run(10);

        // First-request timing and request-to-output latency.
        do_reset(1'b0);
        run(8);
        check("first_gnt_cycle", 32'(first_gnt_cyc - release_cyc), 32'd1);
        check("first_valid_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'(LAT));

        // Redirect to 0x100 with two requests outstanding.
        do_reset(1'b0);
        lat_min = 3; lat_max = 3;
        n = 0;
        while (mem_due_q.size() != 2 && n < 20) begin
            cycle();
            n++;
        end
        if (mem_due_q.size() != 2) begin
            total++;
            bad++;
            $display("FAIL outstanding_setup: got %0d outstanding, want 2", mem_due_q.size());
        end
        force_redirect = 1'b1; force_target = 32'h0000_0100;
        cycle();
        lat_min = 1; lat_max = 1;
        run(20);

        // Unaligned target.
        force_redirect = 1'b1; force_target = 32'h0000_0203;
        run(12);

        // Second redirect while the first is still flushing.
        lat_min = 3; lat_max = 3;
        run(4);
        force_redirect = 1'b1; force_target = 32'h0000_0100;
        cycle();
        force_redirect = 1'b1; force_target = 32'h0000_0300;
        cycle();
        run(20);

        // Randomized traffic with occasional asynchronous reset.
        gnt_pct = 70; rdy_pct = 70; redir_pct = 3; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3; k++) begin
            run(1000);
            do_reset(1'b1);
        end

        // Drain: all granted words since the last redirect must come out.
        gnt_pct = 100; rdy_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 2;
        accepts = 0;
        run(30);
        check("drain_progress", 32'(accepts >= 15), 32'd1);
        gnt_pct = 0;
        run(20);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the in-order RISC-V core, sitting directly upstream of the instruction decoder. It issues word-aligned requests to instruction memory over a request/grant/response interface and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to the decoder over a valid/ready handshake. Branch and jump redirects flush the buffer and discard stale in-flight responses.

## Interface
- DEPTH, 4, FIFO entries and maximum credits (outstanding + buffered); power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, word-aligned
- imem_gnt_i  in  1  request accepted this cycle when imem_req_o=1
- imem_rvalid_i  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  instr_o/pc_o valid for the decoder
- instr_o  out  32  instruction word to the decoder's instr_i
- pc_o  out  32  PC of instr_o
- instr_ready_i  in  1  decoder accepts the instruction

## Operation
- State machine has 3 states.
  - RESET: entered asynchronously. Leaves to FETCH on the first clock edge with rst_ni=1.
  - FETCH: normal operation.
  - FLUSH: discarding stale responses. Returns to FETCH when discard_cnt reaches 0.
- Registers:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next kept response.
  - out_cnt: outstanding granted requests, 0..DEPTH.
  - discard_cnt: 0..DEPTH.
  - FIFO of {pc, instr}, DEPTH entries, with wrapping read/write pointers and a count.
- Request rule:
  - imem_req_o = (state==FETCH) & !redirect_i & (out_cnt + fifo_cnt < DEPTH), using registered counts only.
  - imem_addr_o = fetch_pc.
  - On imem_req_o & imem_gnt_i: fetch_pc += 4 (wraps modulo 2^32) and out_cnt++.
- Response handling:
  - Every imem_rvalid_i decrements out_cnt.
  - If discard_cnt>0 the response is dropped and discard_cnt--.
  - Otherwise {rsp_pc, imem_rdata_i} is pushed to the FIFO and rsp_pc += 4.
- Output: instr_valid_o = fifo non-empty & !redirect_i. Pop when instr_valid_o & instr_ready_i.
- Redirect takes priority over every other event in the same cycle:
  - fetch_pc ← redirect_pc_i & ~3; rsp_pc ← the same value.
  - FIFO is cleared; any response arriving in that cycle is dropped.
  - discard_cnt ← out_cnt after accounting for this cycle's response.
  - Next state = FLUSH if that value is >0, else FETCH.
  - A redirect during FLUSH behaves identically; all outstanding responses stay stale.
- Push and pop in the same cycle on a full FIFO is legal; the count is unchanged.
- Credit rule guarantees the FIFO never overflows, so no response is ever lost.
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0.
  - All counters 0; fetch_pc=rsp_pc=RESET_PC.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset release for pre-reset requests are the memory's responsibility and are not tracked.

## Timing
- Request to output latency, with gnt=1 and rvalid one cycle after grant:
  - Without bypass: grant in cycle N, response in N+1, instr_valid_o in N+2.
  - With bypass: instr_valid_o in N+1.
- First request is issued in the first cycle of FETCH, i.e. the first cycle after reset release.
- Steady-state throughput is 1 instruction/cycle when DEPTH≥4, instr_ready_i=1, gnt=1 and rvalid latency is 1.
- Redirect in cycle R:
  - instr_valid_o=0 and imem_req_o=0 in R.
  - If nothing is outstanding, a request to the target is issued in R+1.
- Back-pressure: instr_o and pc_o hold stable while instr_valid_o=1 and instr_ready_i=0, unless a redirect occurs.

## Configuration
- IFETCH_BYPASS_EN defined:
  - When the FIFO is empty, a kept response is forwarded combinationally to instr_o/pc_o with instr_valid_o=1 in the same cycle.
  - It is pushed to the FIFO only if instr_ready_i=0.
- IFETCH_BYPASS_EN undefined: every response goes through the FIFO, adding one cycle of latency; outputs are driven purely from registers.

## Test plan
- Reset release, gnt=1, rvalid latency 1, ready=1 → addresses 0x0, 0x4, 0x8…; pc_o 0x0, 0x4, … one per cycle; first valid at cycle 2 (cycle 1 with IFETCH_BYPASS_EN).
- Hold instr_ready_i=0 for 10 cycles → imem_req_o drops once out_cnt+fifo_cnt=4; instr_o/pc_o stay stable at pc 0x0. Release → pcs 0x0..0xC in order with no loss.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped; next instr_valid_o has pc_o=0x100; addresses resume at 0x100.
- Redirect to 0x203 → imem_addr_o=0x200 and pc_o=0x200.
- Second redirect to 0x300 issued during FLUSH → no instruction from 0x100 ever appears; first output pc 0x300.
- rst_ni pulsed low mid-stream while asynchronous to clk_i → outputs go to reset values immediately; after release fetch restarts at RESET_PC.
